// File: rtl/b11_core_arbiter.sv
// Round-robin scheduler sharing one b11 scrambler core among NREQ requesters.
// Optional: define B11_ARB_PRIO_EN to give requester 0 absolute priority.
module b11_core_arbiter #(
  parameter int NREQ     = 4,
  parameter int CORE_LAT = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [6*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [5:0]        rsp_data,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic              core_reset,
  output logic              core_stbi,
  output logic [5:0]        core_x_in,
  input  logic [5:0]        core_x_out,
  output logic              busy
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(CORE_LAT + 1);
  localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {INIT, PARK, IDLE, LOAD, WAIT, RESP} state_t;

  state_t          state;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   winner;
  logic [IW-1:0]   grant_idx;
  logic            grant_any;
  logic [CW-1:0]   wait_cnt;
  logic            park_cnt;

  // Descending scan so the nearest index after rr_ptr is the last to be written.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = NREQ; k >= 1; k--) begin
      int idx;
      idx = (int'(rr_ptr) + k) % NREQ;
      if (req_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = IW'(idx);
      end
    end
`ifdef B11_ARB_PRIO_EN
    if (req_valid[0]) begin
      grant_any = 1'b1;
      grant_idx = '0;
    end
`endif
  end

  // Acceptance handshake is only offered while parked in IDLE.
  assign req_ready = (state == IDLE && grant_any) ? (ONE << grant_idx) : '0;
  assign busy      = (state != IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= INIT;
      core_reset <= 1'b1;
      core_stbi  <= 1'b1;
      core_x_in  <= '0;
      rsp_valid  <= '0;
      rsp_data   <= '0;
      rr_ptr     <= IW'(NREQ - 1);
      wait_cnt   <= '0;
      winner     <= '0;
      park_cnt   <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          core_reset <= 1'b0;
          park_cnt   <= 1'b0;
          state      <= PARK;
        end
        PARK: begin
          park_cnt <= 1'b1;
          if (park_cnt) state <= IDLE;
        end
        IDLE: begin
          core_stbi <= 1'b1;
          if (grant_any) begin
            winner    <= grant_idx;
            core_x_in <= req_data[int'(grant_idx)*6 +: 6];
            core_stbi <= 1'b0;
            state     <= LOAD;
          end
        end
        LOAD: begin
          core_stbi <= 1'b1;
          wait_cnt  <= CW'(1);
          state     <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == CW'(CORE_LAT)) begin
            rsp_data  <= core_x_out;
            rsp_valid <= ONE << winner;
            wait_cnt  <= '0;
`ifdef B11_ARB_PRIO_EN
            // A priority win must not disturb the rotation of the others.
            if (winner != '0) rr_ptr <= winner;
`else
            rr_ptr <= winner;
`endif
            state <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready[winner]) begin
            rsp_valid <= '0;
            state     <= IDLE;
          end
        end
        default: state <= INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_b11_core_arbiter.sv
// Randomized self-checking bench for b11_core_arbiter with a behavioural b11 core stand-in.
module tb_b11_core_arbiter;
  localparam int NREQ     = 4;
  localparam int CORE_LAT = 16;

  logic              clock;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [6*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   rsp_valid;
  logic [5:0]        rsp_data;
  logic [NREQ-1:0]   rsp_ready;
  logic              core_reset;
  logic              core_stbi;
  logic [5:0]        core_x_in;
  logic [5:0]        core_x_out;
  logic              busy;

  int checks = 0;
  int errors = 0;
  int rr_m;
  logic [5:0] last_m;

  b11_core_arbiter #(.NREQ(NREQ), .CORE_LAT(CORE_LAT)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .core_reset(core_reset), .core_stbi(core_stbi), .core_x_in(core_x_in),
    .core_x_out(core_x_out), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Core stand-in: 0/63 pass through, 1..26 are scrambled, anything else leaves x_out alone.
  function automatic logic [5:0] core_fn(input logic [5:0] op, input logic [5:0] prev);
    if (op == 6'd0 || op == 6'd63) return op;
    if (op <= 6'd26) return op ^ 6'h2A;
    return prev;
  endfunction

  always @(posedge clock) begin
    if (core_reset) core_x_out <= 6'd0;
    else if (!core_stbi) core_x_out <= core_fn(core_x_in, core_x_out);
  end

  function automatic int exp_winner(input logic [NREQ-1:0] v);
`ifdef B11_ARB_PRIO_EN
    if (v[0]) return 0;
`endif
    for (int k = 1; k <= NREQ; k++)
      if (v[(rr_m + k) % NREQ]) return (rr_m + k) % NREQ;
    return -1;
  endfunction

  task automatic model_commit(input int w, input logic [5:0] op);
    last_m = core_fn(op, last_m);
`ifdef B11_ARB_PRIO_EN
    if (w != 0) rr_m = w;
`else
    rr_m = w;
`endif
  endtask

  function automatic logic [5:0] rand_op();
    case ($urandom_range(0, 3))
      0: return 6'd0;
      1: return 6'd63;
      2: return 6'($urandom_range(1, 26));
      default: return 6'($urandom_range(27, 62));
    endcase
  endfunction

  // Drives one operation end to end; returns what was observed, never judges it.
  task automatic run_op(input logic [NREQ-1:0] vmask, input logic [6*NREQ-1:0] data,
                        input int hold, output int win, output logic [5:0] res,
                        output int lat, output int stb_low, output bit stable,
                        output bit released);
    logic [NREQ-1:0] oh;
    win = -1; lat = -1; stb_low = 0; stable = 1'b1; released = 1'b0; res = '0;
    req_valid = vmask;
    req_data  = data;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (req_ready != '0) begin
        for (int j = 0; j < NREQ; j++) if (req_ready[j]) win = j;
        break;
      end
      @(negedge clock);
    end
    @(negedge clock);
    req_valid = '0;
    if (win >= 0) begin
      oh = 4'b0001 << win;
      for (int k = 1; k <= CORE_LAT + 20; k++) begin
        if (!core_stbi) stb_low++;
        if (rsp_valid != '0) begin lat = k; break; end
        @(negedge clock);
      end
      if (lat > 0) begin
        res = rsp_data;
        if (rsp_valid !== oh) stable = 1'b0;
        for (int h = 0; h < hold; h++) begin
          rsp_ready = ~oh;
          @(negedge clock);
          if (rsp_valid !== oh || rsp_data !== res) stable = 1'b0;
        end
        rsp_ready = oh;
        @(negedge clock);
        released = (rsp_valid == '0);
        rsp_ready = '0;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    rr_m = NREQ - 1;
    last_m = 6'd0;
  endtask

  task automatic test_reset();
    req_valid = 4'hF; req_data = '0; rsp_ready = '0;
    #1 reset = 1'b0;
    repeat (3) @(negedge clock);
    checks++; if (core_reset !== 1'b1 || core_stbi !== 1'b1 || core_x_in !== 6'd0) begin
      errors++; $display("FAIL reset_core: reset=%b stbi=%b x_in=%h, want 1 1 00", core_reset, core_stbi, core_x_in); end
    checks++; if (req_ready !== 4'b0 || rsp_valid !== 4'b0 || rsp_data !== 6'd0 || busy !== 1'b1) begin
      errors++; $display("FAIL reset_outputs: req_ready=%b rsp_valid=%b rsp_data=%h busy=%b, want 0000 0000 00 1",
                         req_ready, rsp_valid, rsp_data, busy); end
    req_valid = '0;
    reset = 1'b1;
    #1;
    checks++; if (core_reset !== 1'b1) begin
      errors++; $display("FAIL init_core_reset: got %b want 1", core_reset); end
    @(negedge clock);
    checks++; if (core_reset !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL park1: core_reset=%b busy=%b, want 0 1", core_reset, busy); end
    @(negedge clock);
    checks++; if (busy !== 1'b1 || core_stbi !== 1'b1) begin
      errors++; $display("FAIL park2: busy=%b stbi=%b, want 1 1", busy, core_stbi); end
    @(negedge clock);
    checks++; if (busy !== 1'b0 || core_stbi !== 1'b1 || core_reset !== 1'b0) begin
      errors++; $display("FAIL idle_entry: busy=%b stbi=%b core_reset=%b, want 0 1 0", busy, core_stbi, core_reset); end
    rr_m = NREQ - 1;
    last_m = 6'd0;
  endtask

  task automatic test_single();
    int w, lat, sl; logic [5:0] r; bit st, rel; logic [6*NREQ-1:0] d;
    d = 24'($urandom); d[5:0] = 6'd0;
    run_op(4'b0001, d, 0, w, r, lat, sl, st, rel);
    checks++; if (w !== 0) begin errors++; $display("FAIL single_grant: got %0d want 0", w); end
    checks++; if (lat !== CORE_LAT + 2) begin errors++; $display("FAIL single_latency: got %0d want %0d", lat, CORE_LAT + 2); end
    checks++; if (sl !== 1) begin errors++; $display("FAIL single_stbi_low: got %0d cycles want 1", sl); end
    checks++; if (r !== 6'd0 || !rel) begin errors++; $display("FAIL single_result: data=%h released=%b, want 00 1", r, rel); end
    model_commit(0, 6'd0);
  endtask

  task automatic test_hold();
    int w, lat, sl; logic [5:0] r; bit st, rel; logic [6*NREQ-1:0] d;
    d = 24'($urandom); d[11:6] = 6'h3F;
    run_op(4'b0010, d, 5, w, r, lat, sl, st, rel);
    checks++; if (w !== 1) begin errors++; $display("FAIL hold_grant: got %0d want 1", w); end
    checks++; if (r !== 6'h3F) begin errors++; $display("FAIL hold_result: got %h want 3f", r); end
    checks++; if (!st || !rel) begin errors++; $display("FAIL hold_stable: stable=%b released=%b want 1 1", st, rel); end
    model_commit(1, 6'h3F);
  endtask

  task automatic test_stale();
    int w, lat, sl; logic [5:0] r; bit st, rel; logic [6*NREQ-1:0] d;
    d = 24'($urandom); d[17:12] = 6'h3F;
    run_op(4'b0100, d, 0, w, r, lat, sl, st, rel);
    checks++; if (w !== 2 || r !== 6'h3F) begin errors++; $display("FAIL stale_first: win=%0d data=%h want 2 3f", w, r); end
    model_commit(2, 6'h3F);
    d = 24'($urandom); d[23:18] = 6'd40;
    run_op(4'b1000, d, 0, w, r, lat, sl, st, rel);
    checks++; if (w !== 3 || r !== last_m) begin errors++; $display("FAIL stale_second: win=%0d data=%h want 3 %h", w, r, last_m); end
    model_commit(3, 6'd40);
  endtask

  task automatic test_rotation();
    int w, lat, sl, ew; logic [5:0] r, eo; bit st, rel; logic [6*NREQ-1:0] d;
    int order [5];
`ifdef B11_ARB_PRIO_EN
    order = '{0, 0, 0, 0, 0};
`else
    order = '{0, 1, 2, 3, 0};
`endif
    do_reset();
    for (int n = 0; n < 5; n++) begin
      d = 24'($urandom);
      ew = exp_winner(4'hF);
      run_op(4'hF, d, 0, w, r, lat, sl, st, rel);
      checks++; if (w !== order[n] || w !== ew) begin
        errors++; $display("FAIL rotation_grant[%0d]: got %0d want %0d", n, w, order[n]); end
      eo = d[ew*6 +: 6];
      model_commit(ew, eo);
      checks++; if (r !== last_m) begin errors++; $display("FAIL rotation_result[%0d]: got %h want %h", n, r, last_m); end
    end
  endtask

  task automatic test_random();
    int w, lat, sl, ew; logic [5:0] r; bit st, rel; logic [6*NREQ-1:0] d; logic [NREQ-1:0] v;
    for (int n = 0; n < 20; n++) begin
      v = 4'($urandom_range(1, 15));
      for (int i = 0; i < NREQ; i++) d[i*6 +: 6] = rand_op();
      ew = exp_winner(v);
      run_op(v, d, $urandom_range(0, 3), w, r, lat, sl, st, rel);
      model_commit(ew, d[ew*6 +: 6]);
      checks++; if (w !== ew || r !== last_m || lat !== CORE_LAT + 2 || !st || !rel) begin
        errors++; $display("FAIL random[%0d]: win=%0d data=%h lat=%0d stable=%b rel=%b want win=%0d data=%h lat=%0d 1 1",
                           n, w, r, lat, st, rel, ew, last_m, CORE_LAT + 2); end
    end
  endtask

  task automatic test_reset_mid();
    int w, lat, sl, stale; logic [5:0] r; bit st, rel, got; logic [6*NREQ-1:0] d;
    got = 1'b0;
    req_data = 24'($urandom); req_data[17:12] = 6'd7;
    req_valid = 4'b0100;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (req_ready != '0) begin got = 1'b1; break; end
      @(negedge clock);
    end
    checks++; if (!got) begin errors++; $display("FAIL midreset_grant: no grant seen"); end
    @(negedge clock);
    req_valid = '0;
    repeat (5) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    checks++; if (rsp_valid !== 4'b0 || rsp_data !== 6'd0 || core_reset !== 1'b1 ||
                  core_stbi !== 1'b1 || core_x_in !== 6'd0 || busy !== 1'b1) begin
      errors++; $display("FAIL midreset_async: rsp_valid=%b rsp_data=%h core_reset=%b stbi=%b x_in=%h busy=%b",
                         rsp_valid, rsp_data, core_reset, core_stbi, core_x_in, busy); end
    @(negedge clock);
    reset = 1'b1;
    rr_m = NREQ - 1;
    last_m = 6'd0;
    stale = 0;
    for (int i = 0; i < CORE_LAT + 5; i++) begin
      @(negedge clock);
      if (rsp_valid != '0) stale++;
    end
    checks++; if (stale !== 0) begin errors++; $display("FAIL midreset_stale: rsp_valid seen %0d cycles want 0", stale); end
    d = 24'($urandom); d[17:12] = 6'd5;
    run_op(4'b0100, d, 0, w, r, lat, sl, st, rel);
    model_commit(2, 6'd5);
    checks++; if (w !== 2 || r !== last_m || lat !== CORE_LAT + 2 || !rel) begin
      errors++; $display("FAIL midreset_after: win=%0d data=%h lat=%0d rel=%b want 2 %h %0d 1",
                         w, r, lat, rel, last_m, CORE_LAT + 2); end
  endtask

  initial begin
    reset = 1'b1; req_valid = '0; req_data = '0; rsp_ready = '0;
    rr_m = NREQ - 1; last_m = 6'd0;
    test_reset();
    test_single();
    test_hold();
    test_stale();
    test_rotation();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
